// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline hazard sequencer for the 5-stage MIPS core.
// It owns the PC, IF/ID and ID/EX write/flush controls and resolves three
// kinds of hazard:
//   - load-use stalls
//   - multi-cycle multiply occupancy of EX
//   - taken branch/jump flushes
// Optional macro HAZ_PERF_CNT_EN adds saturating 16-bit per-hazard cycle counters.
module hazard_stall_controller #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned MUL_LATENCY  = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] ID_Rs,
  input  logic [ADDR_W-1:0] ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              EX_MemRead,
  input  logic [ADDR_W-1:0] EX_RegWriteAddress,
  input  logic              EX_MulStart,
  input  logic              BranchTaken,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              EX_Hold,
  output logic              MulDone
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       LoadStallCnt,
  output logic [15:0]       MulStallCnt,
  output logic [15:0]       FlushCnt
`endif
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH} state_t;

  localparam logic [3:0] MUL_INIT   = 4'(MUL_LATENCY - 2);
  localparam logic [3:0] FLUSH_INIT = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load_use;

  // Load-use match: a load in EX writing a nonzero register that ID reads.
  always_comb begin
    load_use = EX_MemRead && (EX_RegWriteAddress != '0) &&
               ((EX_RegWriteAddress == ID_Rs) ||
                (ID_UsesRt && (EX_RegWriteAddress == ID_Rt)));
  end

  // State and counter register; synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    EX_Hold     = 1'b0;
    MulDone     = 1'b0;
    if (!Rst) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = FLUSH_INIT;
            end
          end else if (EX_MulStart) begin
            EX_Hold    = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            state_nxt  = MUL_WAIT;
            cnt_nxt    = MUL_INIT;
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          EX_Hold    = 1'b1;
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          if (cnt == '0) begin
            MulDone   = 1'b1;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        FLUSH: begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 4'd1;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic ev_load, ev_mul, ev_flush;

  // Hazard-class cycle events derived from the decoded outputs: a stall
  // without EX hold can only be load-use; EX hold is always the multiply.
  always_comb begin
    ev_load  = Rst && !PCWrite && !EX_Hold;
    ev_mul   = EX_Hold;
    ev_flush = IFID_Flush;
  end

  // Saturating per-class cycle counters, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      LoadStallCnt <= '0;
      MulStallCnt  <= '0;
      FlushCnt     <= '0;
    end else begin
      if (ev_load  && (LoadStallCnt != '1)) LoadStallCnt <= LoadStallCnt + 16'd1;
      if (ev_mul   && (MulStallCnt  != '1)) MulStallCnt  <= MulStallCnt  + 16'd1;
      if (ev_flush && (FlushCnt     != '1)) FlushCnt     <= FlushCnt     + 16'd1;
    end
  end
`endif

endmodule
